// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: owns the fetch PC, issues imem word requests and
// buffers returned instructions with their PC+4 ahead of the IF/ID register.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc_plus4,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        FETCH,
        DISCARD
    } state_t;

    state_t          state;
    logic            run;
    logic [31:0]     fetch_pc;
    logic [31:0]     stale_addr;
    logic [31:0]     inst_mem [DEPTH];
    logic [31:0]     pc4_mem  [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            not_full;
    logic            accept;
    logic            push;
    logic            pop;

    assign not_full = count < CW'(DEPTH);

    // run holds the request low until the first edge after reset release
    assign imem_req  = run && ((state == DISCARD) || not_full);
    assign imem_addr = (state == DISCARD) ? stale_addr : fetch_pc;

    assign accept = imem_req && imem_ack;
    assign push   = accept && (state == FETCH) && !redirect;
    assign pop    = out_valid && !stall && !redirect;

    assign out_valid    = (count != '0);
    assign out_inst     = out_valid ? inst_mem[rd_ptr] : 32'd0;
    assign out_pc_plus4 = out_valid ? pc4_mem[rd_ptr]  : 32'd0;
    assign q_count      = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            run        <= 1'b0;
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                unique case (state)
                    FETCH: begin
                        if (imem_req && !imem_ack) begin
                            stale_addr <= fetch_pc;
                            state      <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (imem_ack) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end else begin
                unique case (state)
                    FETCH: begin
                        if (accept) begin
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                    end
                    DISCARD: begin
                        if (accept) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc4_mem[wr_ptr]  <= fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: table-driven stream/stall
// vectors followed by redirect, discard and mid-stream reset sequences.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc_plus4;
    logic [2:0]  q_count;

    fetch_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_inst     (out_inst),
        .out_pc_plus4 (out_pc_plus4),
        .q_count      (q_count)
    );

    always #5 clk = ~clk;

    // Memory model: ack tied high, or ack after a fixed wait
    logic ack_tied = 1'b1;
    int   lat = 3;
    int   wcnt;

    assign imem_ack   = ack_tied ? 1'b1 : (imem_req && (wcnt == lat - 1));
    assign imem_rdata = imem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wcnt <= 0;
        else if (imem_req && !imem_ack)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] pc4;
        int          count;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic s, input logic v,
                                input logic [31:0] p, input int c,
                                input logic r, input logic [31:0] a);
        vec_t x;
        x.stall = s;
        x.valid = v;
        x.pc4   = p;
        x.count = c;
        x.req   = r;
        x.addr  = a;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string t, input logic v,
                             input logic [31:0] p4, input int c,
                             input logic rq, input logic [31:0] ad);
        logic [31:0] ei;
        ei = v ? (p4 - 32'd4) : 32'd0;
        chk({t, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({t, ".pc4"}, out_pc_plus4, p4);
        chk({t, ".inst"}, out_inst, ei);
        chk({t, ".count"}, {29'd0, q_count}, 32'(c));
        chk({t, ".req"}, {31'd0, imem_req}, {31'd0, rq});
        chk({t, ".addr"}, imem_addr, ad);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back(mk(0, 0, 32'd0,  0, 1, 32'd0));
        vecs.push_back(mk(0, 1, 32'd4,  1, 1, 32'd4));
        vecs.push_back(mk(0, 1, 32'd8,  1, 1, 32'd8));
        vecs.push_back(mk(0, 1, 32'd12, 1, 1, 32'd12));
        vecs.push_back(mk(0, 1, 32'd16, 1, 1, 32'd16));
        vecs.push_back(mk(1, 1, 32'd16, 2, 1, 32'd20));
        vecs.push_back(mk(1, 1, 32'd16, 3, 1, 32'd24));
        vecs.push_back(mk(1, 1, 32'd16, 4, 0, 32'd28));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 1, 32'd16, 4, 0, 32'd28));
        vecs.push_back(mk(0, 1, 32'd20, 3, 1, 32'd28));
        vecs.push_back(mk(0, 1, 32'd24, 3, 1, 32'd32));
        vecs.push_back(mk(0, 1, 32'd28, 3, 1, 32'd36));
        vecs.push_back(mk(0, 1, 32'd32, 3, 1, 32'd40));
        vecs.push_back(mk(0, 1, 32'd36, 3, 1, 32'd44));

        #2;
        check_out("reset", 0, 32'd0, 0, 0, 32'd0);
        step();
        step();
        check_out("reset_hold", 0, 32'd0, 0, 0, 32'd0);
        rst_n = 1'b1;

        // Stream, stall fill, release
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc4,
                      vecs[i].count, vecs[i].req, vecs[i].addr);
        end

        // Redirect coinciding with an ack
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check_out("redir_ack", 0, 32'd0, 0, 1, 32'h100);
        step();
        check_out("redir_first", 1, 32'h104, 1, 1, 32'h104);

        // Redirect during an in-flight request, then again in DISCARD
        ack_tied    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        check_out("disc_enter", 0, 32'd0, 0, 1, 32'h104);
        redirect_pc = 32'h300;
        step();
        check_out("disc_redir2", 0, 32'd0, 0, 1, 32'h104);
        redirect = 1'b0;
        step();
        check_out("disc_done", 0, 32'd0, 0, 1, 32'h300);
        step();
        check_out("disc_wait1", 0, 32'd0, 0, 1, 32'h300);
        step();
        check_out("disc_wait2", 0, 32'd0, 0, 1, 32'h300);
        step();
        check_out("disc_target", 1, 32'h304, 1, 1, 32'h304);

        // Queue 3 entries, then reset asynchronously
        ack_tied = 1'b1;
        stall    = 1'b1;
        step();
        check_out("fill2", 1, 32'h304, 2, 1, 32'h308);
        step();
        check_out("fill3", 1, 32'h304, 3, 1, 32'h30c);
        rst_n = 1'b0;
        #1;
        check_out("rst_mid", 0, 32'd0, 0, 0, 32'd0);
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
        step();
        check_out("restart_req", 0, 32'd0, 0, 1, 32'd0);
        step();
        check_out("restart_first", 1, 32'd4, 1, 1, 32'd4);
        step();
        check_out("restart_second", 1, 32'd8, 1, 1, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake. Returned instructions are buffered in a small FIFO together with their PC+4. The decode side pops the FIFO under hazard stall, and branch/jump redirects flush the FIFO and discard any in-flight fetch.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  32  word address of the current request; stable while imem_req=1.
- imem_ack  in  1  on a rising edge where imem_req=1 and imem_ack=1, imem_rdata is valid and the request completes.
- imem_rdata  in  32  instruction word.
- stall  in  1  decode cannot accept this cycle (inverse of IF/ID write enable).
- redirect  in  1  control-flow change; flushes the queue.
- redirect_pc  in  32  new fetch PC, sampled when redirect=1.
- out_valid  out  1  FIFO head holds an instruction.
- out_inst  out  32  head instruction; 0 (NOP) when out_valid=0.
- out_pc_plus4  out  32  head PC+4; 0 when out_valid=0.
- q_count  out  clog2(DEPTH)+1  entries held.

## Operation
- State: fetch_pc (32), stale_addr (32), FIFO (DEPTH x 64: inst, pc+4), rd/wr pointers, count, FSM {FETCH, DISCARD}.
- FETCH:
  - imem_req = (count < DEPTH); imem_addr = fetch_pc.
  - On accepted ack with no redirect: push {imem_rdata, fetch_pc+4}; fetch_pc += 4 (mod 2^32, wraps silently).
- DISCARD:
  - imem_req = 1; imem_addr = stale_addr.
  - On ack: data dropped, go to FETCH.
  - fetch_pc already holds the redirect target.
- Pop occurs when out_valid=1 and stall=0 and redirect=0; the pointer advances and the next head appears the following cycle.
- Push and pop in the same cycle leaves count unchanged; the pushed word lands behind the remaining entries.
- Full: count=DEPTH deasserts imem_req only in FETCH. A request is raised only while count<DEPTH, and pops never reduce room, so a raised request never needs withdrawing and push-on-full cannot occur.
- Redirect, which has priority over push, pop and stall:
  - FIFO is emptied (count=0, pointers reset) and fetch_pc <= redirect_pc.
  - In FETCH with imem_req=1 and imem_ack=0: stale_addr <= fetch_pc, go to DISCARD.
  - In FETCH with ack in the same cycle: the acked word is dropped and the block stays in FETCH.
  - In FETCH with imem_req=0: stays in FETCH.
  - In DISCARD without ack: fetch_pc updates, stays in DISCARD.
  - In DISCARD with ack: the word is dropped, go to FETCH.
- redirect_pc is used as-is; low two bits are not checked.

## Timing
- Reset (async, immediate, while rst_n=0):
  - imem_req=0, imem_addr=RESET_PC.
  - out_valid=0, out_inst=0, out_pc_plus4=0, q_count=0.
  - FSM=FETCH, fetch_pc=RESET_PC.
- First request is asserted in the first cycle after rst_n rises.
- Memory with ack tied high gives one instruction per cycle.
- Latency: the edge that accepts an ack makes that word visible on out_* in the following cycle if the FIFO was empty.
- Outputs out_* and q_count are driven from registered state only (no combinational path from imem_rdata, stall or redirect).
- imem_req and imem_addr are driven from registered state only; no path from imem_ack.
- Redirect penalty: with ack high, the target word appears on out_* 2 cycles after the redirect edge. With an in-flight request, add the remaining ack wait.
- Reset asserted mid-DISCARD abandons the stale request; the memory must tolerate req dropping without ack on reset only.

## Test plan
- Reset, ack tied 1, imem_rdata=imem_addr: out_pc_plus4 sequence 4,8,12,…; out_inst = out_pc_plus4-4; one pop per cycle with stall=0.
- stall=1 for 8 cycles with ack tied 1, then release:
  - Fill phase: q_count rises to 4 and imem_req drops, with no further fetch.
  - After release: the stream resumes with no lost or duplicated PC.
- Redirect to 0x100 on a cycle with ack=1: acked word dropped, queue emptied, next imem_addr=0x100, first out_pc_plus4=0x104 two cycles later.
- Ack latency 3 cycles, redirect to 0x200 one cycle after req rises:
  - imem_addr holds the old address until ack and that word never appears.
  - Then imem_addr=0x200.
  - A second redirect to 0x300 during DISCARD makes 0x300 win.
- count=DEPTH-1 with simultaneous pop and ack: q_count stays 3 and FIFO order is preserved.
- rst_n pulled low mid-stream with 3 entries queued: out_valid, q_count and imem_req go to 0 immediately; after release fetch restarts at RESET_PC.
